// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the register file with scoreboard:
//   default geometry, the hardwired-zero register index, and a helper
//   that locates a port's slice inside a packed multi-port bus.
package regfile_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_NREGS = 32;
   localparam int DEF_NR    = 2;
   localparam int DEF_NW    = 1;

   // Register 0 reads as zero, ignores writes and never goes pending.
   localparam int REG_ZERO  = 0;

   // LSB position of port 'port' in a bus built from slices of 'slice_w' bits.
   function automatic int port_lsb(input int port, input int slice_w);
      return port * slice_w;
   endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// regfile_sb_rdport
//   One combinational read port of regfile_sb.
//   Priority: register 0 -> same-cycle write data (BYPASS=1 only, highest
//   write port wins) -> stored contents qualified by the pending bit.
// Ports:
//   ra        read address
//   we/wa/wd  write-port bundle of the parent (bypass source)
//   mem_flat  stored registers, register r at [r*WIDTH +: WIDTH]
//   pend      pending vector
//   rd        read data
//   rrdy      operand valid this cycle
module regfile_sb_rdport
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NREGS  = DEF_NREGS,
   parameter int NW     = DEF_NW,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic [AW-1:0]          ra,
   input  logic [NW-1:0]          we,
   input  logic [NW*AW-1:0]       wa,
   input  logic [NW*WIDTH-1:0]    wd,
   input  logic [NREGS*WIDTH-1:0] mem_flat,
   input  logic [NREGS-1:0]       pend,
   output logic [WIDTH-1:0]       rd,
   output logic                   rrdy
);

   logic             hit;
   logic [WIDTH-1:0] byp_data;

   // Ascending scan so the highest-indexed matching port is the one kept.
   always_comb begin
      hit      = 1'b0;
      byp_data = '0;
      for (int i = 0; i < NW; i++) begin
         if (we[i] && (wa[port_lsb(i, AW) +: AW] == ra)) begin
            hit      = 1'b1;
            byp_data = wd[port_lsb(i, WIDTH) +: WIDTH];
         end
      end
   end

   always_comb begin
      rd   = '0;
      rrdy = 1'b1;
      if (ra == AW'(REG_ZERO)) begin
         rd   = '0;
         rrdy = 1'b1;
      end else if (hit && (BYPASS != 0)) begin
         rd   = byp_data;
         rrdy = 1'b1;
      end else begin
         rd   = mem_flat[int'(ra) * WIDTH +: WIDTH];
         rrdy = ~pend[ra];
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
//   Multi-port register file with a per-register pending scoreboard and
//   optional write-to-read bypass. NR combinational read ports, NW
//   synchronous write ports, register 0 hardwired to zero.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   we/wa/wd    write enable / address / data per write port (packed)
//   ra          read addresses per read port (packed)
//   rd, rrdy    read data and operand-ready per read port (packed)
//   iss, isa    issue strobe and register to mark pending
//   pend        raw pending vector
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int NREGS  = DEF_NREGS,
   parameter int NR     = DEF_NR,
   parameter int NW     = DEF_NW,
   parameter int BYPASS = 1,
   parameter int AW     = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NW-1:0]       we,
   input  logic [NW*AW-1:0]    wa,
   input  logic [NW*WIDTH-1:0] wd,
   input  logic [NR*AW-1:0]    ra,
   output logic [NR*WIDTH-1:0] rd,
   output logic [NR-1:0]       rrdy,
   input  logic                iss,
   input  logic [AW-1:0]       isa,
   output logic [NREGS-1:0]    pend
);

   logic [WIDTH-1:0]       mem [NREGS];
   logic [NREGS*WIDTH-1:0] mem_flat;
   logic [NREGS-1:0]       pend_q;
   logic [NREGS-1:0]       pend_nxt;
   logic [AW-1:0]          wa_s [NW];
   logic [WIDTH-1:0]       wd_s [NW];
   logic [NW-1:0]          wr_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NW; gi++) begin : g_wslice
         assign wa_s[gi]  = wa[port_lsb(gi, AW) +: AW];
         assign wd_s[gi]  = wd[port_lsb(gi, WIDTH) +: WIDTH];
         assign wr_ok[gi] = we[gi] && (wa_s[gi] != AW'(REG_ZERO));
      end
      for (gi = 0; gi < NREGS; gi++) begin : g_flat
         assign mem_flat[gi*WIDTH +: WIDTH] = mem[gi];
      end
   endgenerate

   // Later ports overwrite earlier ones in the loop, so the highest index
   // wins a write-write collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NREGS; r++) begin
            mem[r] <= '0;
         end
      end else begin
         for (int i = 0; i < NW; i++) begin
            if (wr_ok[i]) begin
               mem[wa_s[i]] <= wd_s[i];
            end
         end
      end
   end

   // Writes retire the older producer; an issue in the same cycle belongs
   // to a younger producer, so the set is applied after the clears.
   always_comb begin
      pend_nxt = pend_q;
      for (int i = 0; i < NW; i++) begin
         if (wr_ok[i]) begin
            pend_nxt[wa_s[i]] = 1'b0;
         end
      end
      if (iss && (isa != AW'(REG_ZERO))) begin
         pend_nxt[isa] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_nxt;
      end
   end

   assign pend = pend_q;

   generate
      for (gi = 0; gi < NR; gi++) begin : g_rd
         regfile_sb_rdport #(
            .WIDTH  (WIDTH),
            .NREGS  (NREGS),
            .NW     (NW),
            .BYPASS (BYPASS),
            .AW     (AW)
         ) u_rdport (
            .ra       (ra[port_lsb(gi, AW) +: AW]),
            .we       (we),
            .wa       (wa),
            .wd       (wd),
            .mem_flat (mem_flat),
            .pend     (pend_q),
            .rd       (rd[port_lsb(gi, WIDTH) +: WIDTH]),
            .rrdy     (rrdy[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
//   Two instances sharing one input bundle: u_byp (BYPASS=1) and u_nob
//   (BYPASS=0), both NREGS=16, NR=3, NW=2, WIDTH=64. Expected outputs are
//   queued by the stimulus process and compared by a separate monitor on
//   the falling edge.
module tb_regfile_sb;

   localparam int W   = 64;
   localparam int N   = 16;
   localparam int NRP = 3;
   localparam int NWP = 2;
   localparam int A   = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NWP-1:0]   we;
   logic [NWP*A-1:0] wa;
   logic [NWP*W-1:0] wd;
   logic [NRP*A-1:0] ra;
   logic             iss;
   logic [A-1:0]     isa;
   logic [NRP*W-1:0] rd_b, rd_n;
   logic [NRP-1:0]   rrdy_b, rrdy_n;
   logic [N-1:0]     pend_b, pend_n;

   regfile_sb #(.WIDTH(W), .NREGS(N), .NR(NRP), .NW(NWP), .BYPASS(1)) u_byp (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
      .rd(rd_b), .rrdy(rrdy_b), .iss(iss), .isa(isa), .pend(pend_b)
   );

   regfile_sb #(.WIDTH(W), .NREGS(N), .NR(NRP), .NW(NWP), .BYPASS(0)) u_nob (
      .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd), .ra(ra),
      .rd(rd_n), .rrdy(rrdy_n), .iss(iss), .isa(isa), .pend(pend_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          cyc;
      int          inst;   // 0 = u_byp, 1 = u_nob
      int          kind;   // 0 = rd, 1 = rrdy, 2 = pend
      int          port;
      logic [63:0] val;
   } exp_t;

   exp_t q[$];

   logic [W-1:0] mem_m [N];
   logic [N-1:0] pend_m;

   function automatic logic [63:0] actual(input int inst, input int kind, input int port);
      if (kind == 0) return (inst == 0) ? rd_b[port*W +: W] : rd_n[port*W +: W];
      if (kind == 1) return {63'd0, (inst == 0) ? rrdy_b[port] : rrdy_n[port]};
      return {48'd0, (inst == 0) ? pend_b : pend_n};
   endfunction

   function automatic string kname(input int kind);
      if (kind == 0) return "rd";
      if (kind == 1) return "rrdy";
      return "pend";
   endfunction

   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] a;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         a = actual(e.inst, e.kind, e.port);
         checks++;
         if (e.cyc != cyc) begin
            failures++;
            $display("FAIL stale_%s inst=%0d port=%0d queued_cyc=%0d now_cyc=%0d", kname(e.kind), e.inst, e.port, e.cyc, cyc);
         end else if (a !== e.val) begin
            failures++;
            $display("FAIL %s inst=%0d port=%0d cyc=%0d actual=%h required=%h", kname(e.kind), e.inst, e.port, cyc, a, e.val);
         end
      end
   end

   task automatic push(input int inst, input int kind, input int port, input logic [63:0] v);
      exp_t e;
      e.cyc = cyc; e.inst = inst; e.kind = kind; e.port = port; e.val = v;
      q.push_back(e);
   endtask

   task automatic exp_rd(input int inst, input int port, input logic [63:0] v);
      push(inst, 0, port, v);
   endtask

   task automatic exp_rdy(input int inst, input int port, input logic b);
      push(inst, 1, port, {63'd0, b});
   endtask

   task automatic exp_pend(input int inst, input logic [N-1:0] v);
      push(inst, 2, 0, {48'd0, v});
   endtask

   task automatic exp_reset_state();
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < NRP; j++) begin
            exp_rd(k, j, 64'd0);
            exp_rdy(k, j, 1'b1);
         end
         exp_pend(k, '0);
      end
   endtask

   task automatic drive(input logic [1:0] we_i, input logic [3:0] wa0, input logic [3:0] wa1,
                        input logic [63:0] wd0, input logic [63:0] wd1,
                        input logic [3:0] ra0, input logic [3:0] ra1, input logic [3:0] ra2,
                        input logic iss_i, input logic [3:0] isa_i);
      we  = we_i;
      wa  = {wa1, wa0};
      wd  = {wd1, wd0};
      ra  = {ra2, ra1, ra0};
      iss = iss_i;
      isa = isa_i;
   endtask

   // Behavioural expectation from the model state and the current inputs.
   task automatic model_exp();
      logic [3:0]  a;
      logic [63:0] v;
      logic        r;
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < NRP; j++) begin
            a = ra[j*A +: A];
            v = mem_m[a];
            r = ~pend_m[a];
            if (k == 0) begin
               for (int i = 0; i < NWP; i++) begin
                  if (we[i] && wa[i*A +: A] == a) begin
                     v = wd[i*W +: W];
                     r = 1'b1;
                  end
               end
            end
            if (a == 4'd0) begin
               v = 64'd0;
               r = 1'b1;
            end
            exp_rd(k, j, v);
            exp_rdy(k, j, r);
         end
         exp_pend(k, pend_m);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < N; r++) mem_m[r] = '0;
      pend_m = '0;
   endtask

   task automatic tick();
      logic [3:0] a;
      if (!rst_n) begin
         model_clear();
      end else begin
         for (int i = 0; i < NWP; i++) begin
            a = wa[i*A +: A];
            if (we[i] && a != 4'd0) begin
               mem_m[a]  = wd[i*W +: W];
               pend_m[a] = 1'b0;
            end
         end
         if (iss && isa != 4'd0) pend_m[isa] = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
      model_clear();
      @(posedge clk);
      #1;

      // reset state
      drive(2'b00, 0, 0, 0, 0, 3, 5, 7, 1'b0, 0);
      exp_reset_state();
      tick();
      rst_n = 1'b1;

      // write r3: bypass sees it now, non-bypass next cycle
      drive(2'b01, 3, 0, 64'h12345678, 0, 3, 0, 0, 1'b0, 0);
      exp_rd(0, 0, 64'h12345678); exp_rd(1, 0, 64'h0);
      exp_rdy(0, 0, 1'b1);        exp_rdy(1, 0, 1'b1);
      tick();
      drive(2'b00, 0, 0, 0, 0, 3, 0, 0, 1'b0, 0);
      exp_rd(0, 0, 64'h12345678); exp_rd(1, 0, 64'h12345678);
      tick();

      // write to r0 ignored
      drive(2'b10, 0, 0, 0, 64'hFFFF, 0, 0, 0, 1'b0, 0);
      exp_rd(0, 0, 64'h0); exp_rd(1, 0, 64'h0);
      exp_rdy(0, 0, 1'b1); exp_rdy(1, 0, 1'b1);
      tick();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
      exp_rd(0, 0, 64'h0); exp_rd(1, 0, 64'h0);
      tick();

      // same-cycle bypass on r9
      drive(2'b01, 9, 0, 64'hA5A5A5A5, 0, 9, 0, 0, 1'b0, 0);
      exp_rd(0, 0, 64'hA5A5A5A5); exp_rd(1, 0, 64'h0);
      tick();
      drive(2'b00, 0, 0, 0, 0, 9, 0, 0, 1'b0, 0);
      exp_rd(0, 0, 64'hA5A5A5A5); exp_rd(1, 0, 64'hA5A5A5A5);
      tick();

      // scoreboard lifecycle on r4
      drive(2'b00, 0, 0, 0, 0, 0, 4, 0, 1'b1, 4);
      exp_rdy(0, 1, 1'b1); exp_rdy(1, 1, 1'b1);
      exp_pend(0, 16'h0000); exp_pend(1, 16'h0000);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(2'b00, 0, 0, 0, 0, 0, 4, 0, 1'b0, 0);
         exp_rdy(0, 1, 1'b0); exp_rdy(1, 1, 1'b0);
         exp_pend(0, 16'h0010); exp_pend(1, 16'h0010);
         tick();
      end
      drive(2'b01, 4, 0, 64'h55, 0, 0, 4, 0, 1'b0, 0);
      exp_rd(0, 1, 64'h55); exp_rdy(0, 1, 1'b1);
      exp_rd(1, 1, 64'h0);  exp_rdy(1, 1, 1'b0);
      exp_pend(0, 16'h0010); exp_pend(1, 16'h0010);
      tick();
      drive(2'b00, 0, 0, 0, 0, 0, 4, 0, 1'b0, 0);
      exp_rd(0, 1, 64'h55); exp_rdy(0, 1, 1'b1);
      exp_rd(1, 1, 64'h55); exp_rdy(1, 1, 1'b1);
      exp_pend(0, 16'h0000); exp_pend(1, 16'h0000);
      tick();

      // write-write collision on r6: port 1 wins
      drive(2'b11, 6, 6, 64'h1, 64'h2, 0, 0, 6, 1'b0, 0);
      exp_rd(0, 2, 64'h2); exp_rd(1, 2, 64'h0);
      tick();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 6, 1'b0, 0);
      exp_rd(0, 2, 64'h2); exp_rd(1, 2, 64'h2);
      exp_pend(0, 16'h0000); exp_pend(1, 16'h0000);
      tick();

      // issue and write r6 together: issue wins, data still written
      drive(2'b01, 6, 0, 64'h77, 0, 0, 0, 6, 1'b1, 6);
      exp_rd(0, 2, 64'h77); exp_rdy(0, 2, 1'b1);
      exp_rd(1, 2, 64'h2);  exp_rdy(1, 2, 1'b1);
      tick();
      drive(2'b00, 0, 0, 0, 0, 0, 0, 6, 1'b0, 0);
      exp_rd(0, 2, 64'h77); exp_rd(1, 2, 64'h77);
      exp_rdy(0, 2, 1'b0);  exp_rdy(1, 2, 1'b0);
      exp_pend(0, 16'h0040); exp_pend(1, 16'h0040);
      tick();

      // mid-run asynchronous reset after r5 write and r7 issue
      drive(2'b01, 5, 0, 64'hDEADBEEF, 0, 5, 7, 0, 1'b1, 7);
      tick();
      drive(2'b00, 0, 0, 0, 0, 5, 7, 0, 1'b0, 0);
      exp_rd(0, 0, 64'hDEADBEEF); exp_rd(1, 0, 64'hDEADBEEF);
      exp_rdy(0, 1, 1'b0);        exp_rdy(1, 1, 1'b0);
      exp_pend(0, 16'h00C0);      exp_pend(1, 16'h00C0);
      tick();
      drive(2'b00, 0, 0, 0, 0, 5, 7, 6, 1'b0, 0);
      #1;
      rst_n = 1'b0;
      exp_reset_state();
      tick();
      rst_n = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 5, 7, 6, 1'b0, 0);
      exp_reset_state();
      tick();

      // randomised cross-check against the behavioural model
      for (int c = 0; c < 3000; c++) begin
         drive(2'($urandom_range(0, 3)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               {$urandom, $urandom}, {$urandom, $urandom},
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         model_exp();
         tick();
      end

      drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain actual=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
